fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// Upstream neighbour of the instruction memory. Holds the program counter, drives
// the combinational IMEM read address, and captures the returned word into the
// IF/ID pipeline register for decode. Honours hazard stalls and branch/jump
// redirects from later stages. Stops fetching cleanly when the PC leaves the
// populated IMEM range.
// PARAMETERS
// RESET_PC    0    word address loaded into PC on reset
// IMEM_DEPTH  256  number of IMEM words; valid word addresses are 0..IMEM_DEPTH-1
// PORTS
// clk              in   1   rising-edge clock
// rst_n            in   1   asynchronous, active-low reset
// stall            in   1   hazard unit: hold PC and IF/ID contents
// redirect         in   1   branch/jump taken: load PC, flush IF/ID
// redirect_target  in   32  word address of the redirect destination
// imem_addr        out  32  IMEM read address (= PC); combinational from PC reg
// imem_data        in   32  IMEM read data; combinational, valid same cycle
// ifid_instr       out  32  captured instruction
// ifid_pc          out  32  word address of ifid_instr
// ifid_pc_plus1    out  32  ifid_pc + 1; used by decode for branch/jump targets
// ifid_valid       out  1   IF/ID holds a real instruction (0 = bubble)
// halted           out  1   high while FSM is in HALT
// fetch_count      out  32  number of valid captures since reset; saturating
// BEHAVIOUR
// - PC is a word address: sequential next PC = PC + 1, 32-bit; wrap is unreachable
//   because of HALT.
// - Reset (rst_n=0, async) sets pc=RESET_PC, ifid_instr=0, ifid_pc=0,
//   ifid_pc_plus1=0, ifid_valid=0, halted=0, fetch_count=0, state=BOOT.
// - FSM states and transitions:
//   BOOT: one idle cycle after reset release. PC holds and nothing is captured.
//     Next state: RUN. redirect is honoured: PC loads target, then RUN or HALT by
//     the range rule.
//   RUN, priority order:
//     1. redirect:
//        - pc <= target, ifid_valid <= 0, ifid_instr <= 0.
//        - If target >= IMEM_DEPTH, next state is HALT.
//        - redirect beats stall.
//     2. stall: pc and all ifid_* hold. fetch_count holds.
//     3. Otherwise:
//        - Capture: ifid_instr <= imem_data, ifid_pc <= pc, ifid_pc_plus1 <= pc+1,
//          ifid_valid <= 1, fetch_count++ (saturating at 0xFFFFFFFF).
//        - pc <= pc + 1.
//        - If pc == IMEM_DEPTH-1, next state is HALT.
//   HALT:
//     - halted=1. PC holds. ifid_valid is forced to 0 on the first HALT edge.
//     - Entry via the last-word capture: the last word stays valid for exactly one
//       cycle, then the bubble.
//     - stall is ignored.
//     - redirect with an in-range target: pc <= target, state goes to RUN. The
//       first capture happens on the following edge.
//     - Out-of-range redirect: pc <= target and the state stays HALT.
// - Latency: the instruction at PC appears on ifid_* one clock after PC is
//   presented. A redirect costs exactly one bubble.
// - fetch_count counts only valid captures: not stalls, flushes or HALT cycles.
// - Reset mid-operation: all state returns to reset values immediately, without
//   waiting for a clock edge.
// TESTING
// 1. Reset, RESET_PC=0, IMEM words 0..3 = 0x2010FFF8, 0x20110008, 0x02119020,
//    0x1240FFFC:
//    - Cycle 1 after release is BOOT with ifid_valid=0.
//    - Then ifid_instr steps through the 4 words with ifid_pc 0,1,2,3 and
//      fetch_count reaches 4.
// 2. stall held 3 cycles at pc=2:
//    - imem_addr stays 2 and ifid_* are unchanged.
//    - After release, ifid_instr=0x02119020 with ifid_pc=2.
// 3. redirect=1, target=0 while pc=4:
//    - Next cycle: ifid_valid=0, pc=0.
//    - Following cycle: ifid_instr=0x2010FFF8 with ifid_pc=0.
// 4. redirect and stall together at pc=3, target=1: redirect wins, bubble, then
//    ifid_pc=1.
// 5. IMEM_DEPTH=8, run sequentially:
//    - After capturing pc=7, halted=1 and ifid_valid drops to 0 one cycle later.
//    - redirect target=2 resumes RUN with ifid_pc=2.
//    - redirect target=300 stays in HALT.
// 6. Assert rst_n low mid-run, between clock edges: all outputs return to reset
//    values before the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
// Holds the word-addressed program counter, presents it to the instruction
// memory as a combinational read address, and captures the returned word into
// the IF/ID pipeline register. Honours hazard stalls and branch/jump redirects,
// and parks in HALT once the PC runs past the populated IMEM range.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   stall            hold PC and IF/ID contents
//   redirect         branch/jump taken: load PC from redirect_target, flush IF/ID
//   redirect_target  word address of the redirect destination
//   imem_addr        IMEM read address (= PC)
//   imem_data        IMEM read data, valid in the same cycle
//   ifid_instr       captured instruction
//   ifid_pc          word address of ifid_instr
//   ifid_pc_plus1    ifid_pc + 1
//   ifid_valid       IF/ID holds a real instruction (0 = bubble)
//   halted           high while in HALT
//   fetch_count      saturating count of valid captures since reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);
  localparam logic [31:0] LAST  = 32'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr_nx, ipc_nx, plus1_nx, cnt_nx;
  logic        valid_nx;
  logic        target_ok;

  assign target_ok = (redirect_target < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      ifid_instr    <= instr_nx;
      ifid_pc       <= ipc_nx;
      ifid_pc_plus1 <= plus1_nx;
      ifid_valid    <= valid_nx;
      fetch_count   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = ifid_instr;
    ipc_nx   = ifid_pc;
    plus1_nx = ifid_pc_plus1;
    valid_nx = ifid_valid;
    cnt_nx   = fetch_count;
    unique case (state)
      BOOT: begin
        state_nx = RUN;
        if (redirect) begin
          pc_nx    = redirect_target;
          instr_nx = '0;
          valid_nx = 1'b0;
          if (!target_ok) state_nx = HALT;
        end
      end
      RUN: begin
        if (redirect) begin
          // redirect outranks stall: the flushed slot is a bubble either way
          pc_nx    = redirect_target;
          instr_nx = '0;
          valid_nx = 1'b0;
          if (!target_ok) state_nx = HALT;
        end else if (!stall) begin
          instr_nx = imem_data;
          ipc_nx   = pc;
          plus1_nx = pc + 32'd1;
          valid_nx = 1'b1;
          if (fetch_count != '1) cnt_nx = fetch_count + 32'd1;
          pc_nx    = pc + 32'd1;
          // the last populated word is still captured; HALT then bubbles it out
          if (pc >= LAST) state_nx = HALT;
        end
      end
      HALT: begin
        valid_nx = 1'b0;
        if (redirect) begin
          pc_nx    = redirect_target;
          instr_nx = '0;
          if (target_ok) state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed bench for fetch_stage.
// Two instances share stall/redirect stimulus: dut_a (IMEM_DEPTH=256) and
// dut_b (IMEM_DEPTH=8). Only one is out of reset at a time; sel picks whose
// outputs are compared.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_na, rst_nb;
  logic        stall, redirect;
  logic [31:0] target;

  logic [31:0] addr_a, data_a, instr_a, ipc_a, plus1_a, cnt_a;
  logic        valid_a, halted_a;
  logic [31:0] addr_b, data_b, instr_b, ipc_b, plus1_b, cnt_b;
  logic        valid_b, halted_b;

  bit sel;
  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2010FFF8;
      32'd1:   return 32'h20110008;
      32'd2:   return 32'h02119020;
      32'd3:   return 32'h1240FFFC;
      default: return 32'hA000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign data_a = imem_word(addr_a);
  assign data_b = imem_word(addr_b);

  fetch_stage #(.RESET_PC(32'd0), .IMEM_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_na), .stall(stall), .redirect(redirect),
    .redirect_target(target), .imem_addr(addr_a), .imem_data(data_a),
    .ifid_instr(instr_a), .ifid_pc(ipc_a), .ifid_pc_plus1(plus1_a),
    .ifid_valid(valid_a), .halted(halted_a), .fetch_count(cnt_a)
  );

  fetch_stage #(.RESET_PC(32'd0), .IMEM_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_nb), .stall(stall), .redirect(redirect),
    .redirect_target(target), .imem_addr(addr_b), .imem_data(data_b),
    .ifid_instr(instr_b), .ifid_pc(ipc_b), .ifid_pc_plus1(plus1_b),
    .ifid_valid(valid_b), .halted(halted_b), .fetch_count(cnt_b)
  );

  typedef struct {
    bit          st;
    bit          rd;
    logic [31:0] tg;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] plus1;
    bit          valid;
    bit          halted;
    logic [31:0] cnt;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(bit st, bit rd, logic [31:0] tg, logic [31:0] addr,
                              logic [31:0] instr, logic [31:0] ipc,
                              logic [31:0] plus1, bit valid, bit halted,
                              logic [31:0] cnt);
    vec_t v;
    v.st = st; v.rd = rd; v.tg = tg; v.addr = addr; v.instr = instr;
    v.ipc = ipc; v.plus1 = plus1; v.valid = valid; v.halted = halted; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    if (!sel) begin
      chk("imem_addr", idx, addr_a, v.addr);
      chk("ifid_instr", idx, instr_a, v.instr);
      chk("ifid_pc", idx, ipc_a, v.ipc);
      chk("ifid_pc_plus1", idx, plus1_a, v.plus1);
      chk("ifid_valid", idx, {31'd0, valid_a}, {31'd0, v.valid});
      chk("halted", idx, {31'd0, halted_a}, {31'd0, v.halted});
      chk("fetch_count", idx, cnt_a, v.cnt);
    end else begin
      chk("imem_addr", idx, addr_b, v.addr);
      chk("ifid_instr", idx, instr_b, v.instr);
      chk("ifid_pc", idx, ipc_b, v.ipc);
      chk("ifid_pc_plus1", idx, plus1_b, v.plus1);
      chk("ifid_valid", idx, {31'd0, valid_b}, {31'd0, v.valid});
      chk("halted", idx, {31'd0, halted_b}, {31'd0, v.halted});
      chk("fetch_count", idx, cnt_b, v.cnt);
    end
  endtask

  task automatic apply(input vec_t v);
    stall = v.st; redirect = v.rd; target = v.tg;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t rst_v;

  initial begin
    // -------- dut_a: depth 256 (fetch, stall, redirect, redirect+stall)
    //            st rd tg      addr   instr          ipc   plus1 vld hlt cnt
    va.push_back(mk(0, 0, 0,     0,  32'h0,          0,    0,   0, 0, 0)); // BOOT
    va.push_back(mk(0, 0, 0,     1,  32'h2010FFF8,   0,    1,   1, 0, 1));
    va.push_back(mk(0, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 2));
    va.push_back(mk(0, 0, 0,     3,  32'h02119020,   2,    3,   1, 0, 3));
    va.push_back(mk(0, 0, 0,     4,  32'h1240FFFC,   3,    4,   1, 0, 4));
    va.push_back(mk(0, 1, 0,     0,  32'h0,          3,    4,   0, 0, 4)); // redirect @pc=4
    va.push_back(mk(0, 0, 0,     1,  32'h2010FFF8,   0,    1,   1, 0, 5));
    va.push_back(mk(0, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 6));
    va.push_back(mk(1, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 6)); // stall x3 @pc=2
    va.push_back(mk(1, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 6));
    va.push_back(mk(1, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 6));
    va.push_back(mk(0, 0, 0,     3,  32'h02119020,   2,    3,   1, 0, 7));
    va.push_back(mk(1, 1, 1,     1,  32'h0,          2,    3,   0, 0, 7)); // redirect beats stall
    va.push_back(mk(0, 0, 0,     2,  32'h20110008,   1,    2,   1, 0, 8));

    // -------- dut_b: depth 8 (last-word halt, HALT redirects)
    vb.push_back(mk(0, 0, 0,     0,  32'h0,          0,    0,   0, 0, 0)); // BOOT
    for (int k = 1; k <= 8; k++)
      vb.push_back(mk(0, 0, 0, 32'(k), imem_word(32'(k - 1)), 32'(k - 1), 32'(k),
                      1, (k == 8), 32'(k)));
    vb.push_back(mk(1, 0, 0,     8,  32'hA0000007,   7,    8,   0, 1, 8)); // bubble, stall ignored
    vb.push_back(mk(0, 0, 0,     8,  32'hA0000007,   7,    8,   0, 1, 8));
    vb.push_back(mk(0, 1, 2,     2,  32'h0,          7,    8,   0, 0, 8)); // resume
    vb.push_back(mk(0, 0, 0,     3,  32'h02119020,   2,    3,   1, 0, 9));
    vb.push_back(mk(0, 1, 300, 300,  32'h0,          2,    3,   0, 1, 9)); // out-of-range from RUN
    vb.push_back(mk(0, 0, 0,   300,  32'h0,          2,    3,   0, 1, 9));
    vb.push_back(mk(1, 1, 300, 300,  32'h0,          2,    3,   0, 1, 9)); // out-of-range from HALT
    vb.push_back(mk(0, 1, 7,     7,  32'h0,          2,    3,   0, 0, 9));
    vb.push_back(mk(0, 0, 0,     8,  32'hA0000007,   7,    8,   1, 1, 10));
    vb.push_back(mk(0, 0, 0,     8,  32'hA0000007,   7,    8,   0, 1, 10));

    rst_v = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);

    rst_na = 1'b0; rst_nb = 1'b0;
    stall = 1'b0; redirect = 1'b0; target = '0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk_all(-1, rst_v);
    rst_na = 1'b1;
    foreach (va[i]) begin
      apply(va[i]);
      chk_all(i, va[i]);
    end

    // asynchronous reset between edges: outputs clear before the next posedge
    stall = 1'b0; redirect = 1'b0;
    #2 rst_na = 1'b0;
    #1 chk_all(100, rst_v);
    @(negedge clk);
    chk_all(101, rst_v);

    sel = 1'b1;
    chk_all(199, rst_v);
    rst_nb = 1'b1;
    foreach (vb[i]) begin
      apply(vb[i]);
      chk_all(200 + i, vb[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
